ser_to_par: RTL and testbench

Receive-side 1:10 deserializer for one TMDS lane of the HDMI path: the inverse of the lane serializer on the transmit side. It accepts two bits per `clk_5x` cycle from a DDR input register (rising- and falling-edge samples), reassembles 10-bit TMDS characters LSB-first, and word-aligns them by bit-slipping until TMDS control tokens are seen consistently. Its output feeds a TMDS decoder running on the pixel-rate strobe it generates.

---
 rtl/ser_to_par_if.sv | 20 ++
 rtl/ser_to_par.sv | 120 ++++++++++++
 tb/tb_ser_to_par.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ser_to_par_if.sv
// Lane-side signal bundle of the TMDS 1:10 deserializer: DDR bit pair in,
// aligned character, pixel-rate strobe and alignment status out.
interface ser_to_par_if;
    logic       data_rise;
    logic       data_fall;
    logic [9:0] data_out;
    logic       data_valid;
    logic       locked;
    logic [3:0] bit_offset;

    // master: the DDR input register / consumer side; slave: the deserializer.
    modport master (
        output data_rise, data_fall,
        input  data_out, data_valid, locked, bit_offset
    );
    modport slave (
        input  data_rise, data_fall,
        output data_out, data_valid, locked, bit_offset
    );
endinterface

// File: rtl/ser_to_par.sv
// TMDS lane 1:10 deserializer with control-token word alignment by bit-slip.
// Optional `TMDS_PN_SWAP_EN inverts both DDR samples to undo a board P/N swap.
module ser_to_par #(
    parameter int TOKEN_CNT    = 8,
    parameter int SLIP_WAIT    = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic        clk_5x,
    input  logic        sys_rst_n,
    ser_to_par_if.slave lane
);
    localparam int MATCH_W = $clog2(TOKEN_CNT + 1);
    localparam int MISS_W  = $clog2(SLIP_WAIT + 1);
    localparam int TOUT_W  = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state;
    logic [2:0]          cnt;
    logic [19:0]         win;
    logic [9:0]          data_q;
    logic                data_valid_q;
    logic                is_token;
    logic [3:0]          offset_q;
    logic [MATCH_W-1:0]  match_cnt;
    logic [MISS_W-1:0]   miss_cnt;
    logic [TOUT_W-1:0]   timeout_cnt;

    logic                bit_rise;
    logic                bit_fall;
    logic [9:0]          slice;

`ifdef TMDS_PN_SWAP_EN
    assign bit_rise = ~lane.data_rise;
    assign bit_fall = ~lane.data_fall;
`else
    assign bit_rise = lane.data_rise;
    assign bit_fall = lane.data_fall;
`endif

    // Oldest bit sits at win[0], so shifting right by the offset selects the word start.
    assign slice = 10'(win >> offset_q);

    function automatic logic token_match(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    // NOTE: every register here, the shift window included, is cleared by reset so
    // the first words after release are deterministic; all updates are non-blocking
    // because each one must see the values from before this edge.
    always_ff @(posedge clk_5x or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= SEARCH;
            cnt          <= '0;
            win          <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            is_token     <= 1'b0;
            offset_q     <= '0;
            match_cnt    <= '0;
            miss_cnt     <= '0;
            timeout_cnt  <= '0;
        end else begin
            cnt          <= (cnt == 3'd4) ? 3'd0 : cnt + 3'd1;
            win          <= {bit_fall, bit_rise, win[19:2]};
            data_valid_q <= (cnt == 3'd4);

            if (cnt == 3'd4) begin
                data_q   <= slice;
                is_token <= token_match(slice);
            end

            // Alignment decisions are made once per word, while the strobe is high.
            if (data_valid_q) begin
                unique case (state)
                    SEARCH: begin
                        if (is_token) begin
                            miss_cnt <= '0;
                            if (match_cnt == MATCH_W'(TOKEN_CNT - 1)) begin
                                state     <= LOCKED;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + MATCH_W'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                            if (miss_cnt == MISS_W'(SLIP_WAIT - 1)) begin
                                offset_q <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end
                    end
                    LOCKED: begin
                        if (is_token) begin
                            timeout_cnt <= '0;
                        end else if (timeout_cnt == TOUT_W'(LOCK_TIMEOUT - 1)) begin
                            state       <= SEARCH;
                            timeout_cnt <= '0;
                            match_cnt   <= '0;
                            miss_cnt    <= '0;
                        end else begin
                            timeout_cnt <= timeout_cnt + TOUT_W'(1);
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign lane.data_out   = data_q;
    assign lane.data_valid = data_valid_q;
    assign lane.locked     = (state == LOCKED);
    assign lane.bit_offset = offset_q;
endmodule

// File: tb/tb_ser_to_par.sv
// Scoreboard bench for ser_to_par: a bit-history reference model predicts each
// captured word, offset and lock state; a monitor compares on every strobe.
`timescale 1ns/1ps
module tb_ser_to_par;
  localparam int TOKEN_CNT    = 8;
  localparam int SLIP_WAIT    = 16;
  localparam int LOCK_TIMEOUT = 4096;
`ifdef TMDS_PN_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  typedef struct {
    logic [9:0] word;
    logic [3:0] off;
    logic       lock_after;
  } exp_t;

  logic clk_5x = 1'b0;
  logic sys_rst_n = 1'b0;

  ser_to_par_if lane();

  ser_to_par #(
    .TOKEN_CNT    (TOKEN_CNT),
    .SLIP_WAIT    (SLIP_WAIT),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clk_5x    (clk_5x),
    .sys_rst_n (sys_rst_n),
    .lane      (lane)
  );

  always #4 clk_5x = ~clk_5x;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   epoch = 0;
  bit   hist[$];
  exp_t sb[$];

  // Reference model state: alignment rules applied word by word.
  bit m_locked;
  int m_match, m_miss, m_to, m_off;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rx_bit(input int idx);
    if (idx < 0) return 1'b0;
    return hist[idx] ^ SWAP;
  endfunction

  function automatic bit is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_match  = 0;
    m_miss   = 0;
    m_to     = 0;
    m_off    = 0;
  endtask

  // Word m is captured from the ten bits starting at stream bit 10m-12+offset.
  task automatic model_capture(input int m);
    logic [9:0] w;
    bit tok;
    exp_t e;
    for (int i = 0; i < 10; i++) w[i] = rx_bit(10 * m - 12 + m_off + i);
    tok    = is_tok(w);
    e.word = w;
    e.off  = 4'(m_off);
    if (!m_locked) begin
      if (tok) begin
        m_match++;
        m_miss = 0;
        if (m_match == TOKEN_CNT) begin m_locked = 1'b1; m_match = 0; end
      end else begin
        m_match = 0;
        m_miss++;
        if (m_miss == SLIP_WAIT) begin m_off = (m_off + 1) % 10; m_miss = 0; end
      end
    end else if (tok) begin
      m_to = 0;
    end else begin
      m_to++;
      if (m_to == LOCK_TIMEOUT) begin m_locked = 1'b0; m_to = 0; end
    end
    e.lock_after = m_locked;
    sb.push_back(e);
  endtask

  task automatic put_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) hist.push_back(w[i]);
  endtask

  task automatic put_zeros(input int k);
    for (int i = 0; i < k; i++) hist.push_back(1'b0);
  endtask

  // Called at a falling edge: presents the pair for cycle cyc (cnt == cyc % 5).
  task automatic drive_cycle();
    while (hist.size() < 2 * cyc + 2) hist.push_back(1'b0);
    lane.data_rise = hist[2 * cyc];
    lane.data_fall = hist[2 * cyc + 1];
    if (cyc % 5 == 4) model_capture((cyc - 4) / 5);
    cyc++;
  endtask

  task automatic drive_all();
    while (2 * cyc < hist.size()) begin
      @(negedge clk_5x);
      drive_cycle();
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk_5x);
      drive_cycle();
    end
  endtask

  task automatic do_reset();
    @(posedge clk_5x);
    #1;
    sys_rst_n = 1'b0;
    epoch++;
    sb.delete();
    hist.delete();
    cyc = 0;
    model_reset();
  endtask

  task automatic release_rst();
    @(negedge clk_5x);
    sys_rst_n = 1'b1;
    drive_cycle();
  endtask

  // Monitor: pops one expectation per strobe, checks lock one cycle later.
  int   mon_epoch = 0;
  int   since = 0;
  bit   seen = 1'b0;
  bit   pend = 1'b0;
  logic exp_lock = 1'b0;

  always @(negedge clk_5x) begin
    if (mon_epoch != epoch) begin
      mon_epoch = epoch;
      seen = 1'b0;
      pend = 1'b0;
    end
    if (sys_rst_n) begin
      if (pend) begin
        check("locked_after_word", 32'(lane.locked), 32'(exp_lock));
        pend = 1'b0;
      end
      since++;
      if (lane.data_valid) begin
        check("scoreboard_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("data_out", 32'(lane.data_out), 32'(e.word));
          check("bit_offset", 32'(lane.bit_offset), 32'(e.off));
          exp_lock = e.lock_after;
          pend = 1'b1;
        end
        if (seen) check("valid_period", 32'(since), 32'd5);
        seen = 1'b1;
        since = 0;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    lane.data_rise = 1'b0;
    lane.data_fall = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_5x);
    #1;
    check("rst_data_out", 32'(lane.data_out), 32'd0);
    check("rst_data_valid", 32'(lane.data_valid), 32'd0);
    check("rst_locked", 32'(lane.locked), 32'd0);
    check("rst_bit_offset", 32'(lane.bit_offset), 32'd0);

    // Aligned token stream, then random traffic with a token every 100 words.
    put_zeros(8);
    repeat (20) put_word(10'h354);
    release_rst();
    drive_all();
    check("aligned_locked", 32'(lane.locked), 32'd1);
    check("aligned_offset", 32'(lane.bit_offset), 32'd0);
    for (int i = 0; i < 300; i++) put_word((i % 100 == 0) ? 10'h354 : 10'($urandom_range(0, 1023)));
    drive_all();

    // Reset pulse between clock edges while locked.
    while (cyc % 5 != 2) idle(1);
    check("pre_pulse_locked", 32'(lane.locked), 32'd1);
    do_reset();
    #1;
    check("pulse_locked", 32'(lane.locked), 32'd0);
    check("pulse_data_out", 32'(lane.data_out), 32'd0);
    check("pulse_bit_offset", 32'(lane.bit_offset), 32'd0);
    check("pulse_data_valid", 32'(lane.data_valid), 32'd0);

    // Stream delayed by 3 bits: slips to offset 3 and relocks.
    put_zeros(11);
    repeat (90) put_word(10'h354);
    release_rst();
    drive_all();
    check("delayed_locked", 32'(lane.locked), 32'd1);
    check("delayed_offset", 32'(lane.bit_offset), 32'd3);

    // Lock held by a token at word 4000, then dropped after 4096 non-tokens.
    repeat (3999) put_word(10'h1F0);
    put_word(10'h354);
    repeat (LOCK_TIMEOUT) put_word(10'h1F0);
    drive_all();
    idle(16);
    check("timeout_unlocked", 32'(lane.locked), 32'd0);
    check("timeout_offset_kept", 32'(lane.bit_offset), 32'd3);

    // Bit-inverted token stream: decodes as 0AB normally, 354 with P/N swap.
    do_reset();
    put_zeros(8);
    repeat (20) put_word(10'h0AB);
    release_rst();
    drive_all();
    check("inverted_locked", 32'(lane.locked), 32'd1);
    check("inverted_word", 32'(lane.data_out), SWAP ? 32'h354 : 32'h0AB);
    check("inverted_offset", 32'(lane.bit_offset), 32'd0);
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
